tdm_demux8: RTL and testbench

Receive end of the 8-channel, 1-bit-per-slot time-division link whose transmitter selects one of eight inputs per slot through the 3-to-8 decoder / 8:1 mux path. Samples the serial line once per enabled slot, tracks slot position with a 3-bit counter locked to a frame-sync marker, and presents all eight channel bits as one registered parallel word per frame. Includes sync hunting, flywheel tolerance of missed markers, and error reporting. Sits between the link's serial input and the per-channel consumers.

---
 rtl/tdm_demux8_pkg.sv | 13 +
 rtl/tdm_demux8_if.sv | 24 ++
 rtl/tdm_demux8.sv | 124 ++++++++++++
 tb/tb_tdm_demux8.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux8_pkg.sv
// Shared definitions for the 8-slot TDM link: slot geometry and link state.
// Used by both the receive demux and the transmitter's slot counter.
package tdm_demux8_pkg;

  localparam int unsigned NUM_SLOTS = 8;
  localparam int unsigned SLOT_W    = 3;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } link_state_t;

endpackage : tdm_demux8_pkg

// File: rtl/tdm_demux8_if.sv
// Serial-in / parallel-out bundle of the TDM receive demux.
// The master drives the slot strobe and serial line; the slave returns the frame.
interface tdm_demux8_if;
  import tdm_demux8_pkg::*;

  logic                 en;
  logic                 sync;
  logic                 din;
  logic [NUM_SLOTS-1:0] y;
  logic                 frame_valid;
  logic                 locked;
  logic                 sync_err;

  modport master (
    output en, sync, din,
    input  y, frame_valid, locked, sync_err
  );

  modport slave (
    input  en, sync, din,
    output y, frame_valid, locked, sync_err
  );

endinterface : tdm_demux8_if

// File: rtl/tdm_demux8.sv
// Receive end of the 8-channel TDM link: hunts for the frame marker, flywheels
// over up to MISS_MAX-1 missing markers and emits one parallel word per frame.
module tdm_demux8
  import tdm_demux8_pkg::*;
#(
  parameter int unsigned MISS_MAX = 2
) (
  input logic          clk,
  input logic          rst_n,
  tdm_demux8_if.slave  link
);

  localparam logic [SLOT_W:0] MISS_LIM = (SLOT_W+1)'(MISS_MAX);

  link_state_t          state_q, state_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [NUM_SLOTS-2:0] shadow_q, shadow_d;
  logic [SLOT_W-1:0]    miss_q, miss_d;
  logic [NUM_SLOTS-1:0] y_q, y_d;
  logic                 fv_q, fv_d;
  logic                 err_q, err_d;

  logic                 wr_en;
  logic [SLOT_W-1:0]    wr_slot;
  logic [NUM_SLOTS-2:0] shadow_we;
  logic [SLOT_W:0]      miss_inc;

  // NOTE: every register here is a flop with its own reset value; non-blocking
  // assignments keep all of them updating from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      slot_q   <= '0;
      shadow_q <= '0;
      miss_q   <= '0;
      y_q      <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      slot_q   <= slot_d;
      shadow_q <= shadow_d;
      miss_q   <= miss_d;
      y_q      <= y_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  assign miss_inc = {1'b0, miss_q} + 1'b1;

  // NOTE: every signal written below gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    miss_d  = miss_q;
    y_d     = y_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    wr_en   = 1'b0;
    wr_slot = slot_q;

    if (link.en) begin
      unique case (state_q)
        HUNT: begin
          if (link.sync) begin
            wr_en   = 1'b1;
            wr_slot = '0;
            slot_d  = SLOT_W'(1);
            miss_d  = '0;
            state_d = LOCK;
          end
        end
        LOCK: begin
          if (link.sync) begin
            // A marker anywhere but slot 0 realigns the frame onto itself.
            err_d   = (slot_q != '0);
            wr_en   = 1'b1;
            wr_slot = '0;
            slot_d  = SLOT_W'(1);
            miss_d  = '0;
          end else if (slot_q == '0) begin
            err_d = 1'b1;
            if (miss_inc < MISS_LIM) begin
              wr_en  = 1'b1;
              slot_d = SLOT_W'(1);
              miss_d = miss_inc[SLOT_W-1:0];
            end else begin
              state_d = HUNT;
              slot_d  = '0;
              miss_d  = '0;
            end
          end else if (slot_q == SLOT_W'(NUM_SLOTS-1)) begin
            y_d    = {link.din, shadow_q};
            fv_d   = 1'b1;
            slot_d = '0;
          end else begin
            wr_en  = 1'b1;
            slot_d = slot_q + 1'b1;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    // One-hot slot decode selects the single shadow bit written this strobe.
    for (int k = 0; k < NUM_SLOTS-1; k++) begin
      shadow_we[k] = wr_en && (wr_slot == SLOT_W'(k));
    end
    shadow_d = shadow_q;
    for (int k = 0; k < NUM_SLOTS-1; k++) begin
      if (shadow_we[k]) shadow_d[k] = link.din;
    end
  end

  always_comb begin
    link.y           = y_q;
    link.frame_valid = fv_q;
    link.sync_err    = err_q;
    link.locked      = (state_q == LOCK);
  end

endmodule : tdm_demux8

// File: tb/tb_tdm_demux8.sv
// Directed plus randomized bench for tdm_demux8 against a slot-array reference
// model that applies the receiver rules strobe by strobe.
module tb_tdm_demux8;

  localparam int MISS_MAX = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tdm_demux8_if link ();

  tdm_demux8 #(.MISS_MAX(MISS_MAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .link  (link)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: where the receiver thinks it is and what it has heard.
  bit       m_locked;
  int       m_slot;
  int       m_miss;
  bit       m_bits [8];
  bit [7:0] m_y;
  bit       m_fv;
  bit       m_err;

  task automatic model_reset();
    m_locked = 0; m_slot = 0; m_miss = 0; m_y = 8'h00; m_fv = 0; m_err = 0;
    foreach (m_bits[i]) m_bits[i] = 0;
  endtask

  task automatic model_step(input bit e, input bit s, input bit d);
    m_fv  = 0;
    m_err = 0;
    if (!e) return;
    if (!m_locked) begin
      if (s) begin
        m_bits[0] = d; m_slot = 1; m_miss = 0; m_locked = 1;
      end
    end else if (s) begin
      m_err = (m_slot != 0);
      m_bits[0] = d; m_slot = 1; m_miss = 0;
    end else if (m_slot == 0) begin
      m_err = 1;
      if (m_miss + 1 < MISS_MAX) begin
        m_bits[0] = d; m_slot = 1; m_miss++;
      end else begin
        m_locked = 0; m_slot = 0; m_miss = 0;
      end
    end else begin
      m_bits[m_slot] = d;
      if (m_slot == 7) begin
        for (int i = 0; i < 8; i++) m_y[i] = m_bits[i];
        m_fv = 1;
        m_slot = 0;
      end else begin
        m_slot++;
      end
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".y"},           link.y,                   m_y);
    check({tag, ".frame_valid"}, {7'd0, link.frame_valid}, {7'd0, m_fv});
    check({tag, ".locked"},      {7'd0, link.locked},      {7'd0, m_locked});
    check({tag, ".sync_err"},    {7'd0, link.sync_err},    {7'd0, m_err});
  endtask

  // One clock: drive on the falling edge, sample 1 ns after the rising edge.
  task automatic cycle(input bit e, input bit s, input bit d, input string tag);
    @(negedge clk);
    link.en = e; link.sync = s; link.din = d;
    @(posedge clk);
    #1;
    model_step(e, s, d);
    check_all(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'($urandom), 1'($urandom), tag);
  endtask

  task automatic send_frame(input bit [7:0] data, input bit with_sync,
                            input int gap, input string tag);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b1, with_sync && (k == 0), data[k], tag);
      idle(gap, tag);
    end
  endtask

  int fv_seen;

  initial begin
    link.en = 0; link.sync = 0; link.din = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Sync-less strobes in HUNT must be ignored entirely.
    for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 1'($urandom), "hunt_nosync");
    check("hunt_y_zero", link.y, 8'h00);

    // Two back-to-back frames.
    cycle(1'b1, 1'b1, 1'b1, "lock_first");
    check("locked_after_first", {7'd0, link.locked}, 8'd1);
    for (int k = 1; k < 8; k++) cycle(1'b1, 1'b0, 1'((8'hA5 >> k) & 1), "frame_a5");
    check("y_a5", link.y, 8'hA5);
    check("fv_a5", {7'd0, link.frame_valid}, 8'd1);
    send_frame(8'h3C, 1'b1, 0, "frame_3c");
    check("y_3c", link.y, 8'h3C);

    // Single missing marker is flywheeled.
    send_frame(8'h81, 1'b0, 0, "miss_one");
    check("y_81", link.y, 8'h81);
    check("locked_after_miss", {7'd0, link.locked}, 8'd1);

    // Two consecutive missing markers drop lock at the second slot 0.
    send_frame(8'h42, 1'b1, 0, "pre_miss2");
    send_frame(8'h66, 1'b0, 0, "miss2_a");
    cycle(1'b1, 1'b0, 1'b1, "miss2_drop");
    check("locked_dropped", {7'd0, link.locked}, 8'd0);
    check("err_on_drop", {7'd0, link.sync_err}, 8'd1);
    fv_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b0, 1'($urandom), "after_drop");
      fv_seen += int'(link.frame_valid);
    end
    check("no_fv_after_drop", 8'(fv_seen), 8'd0);
    check("y_held_in_hunt", link.y, 8'h66);

    // Early marker at slot 4 realigns.
    send_frame(8'h0F, 1'b1, 0, "relock");
    for (int k = 0; k < 4; k++) cycle(1'b1, k == 0, 1'b1, "partial");
    cycle(1'b1, 1'b1, 1'b0, "early_marker");
    check("err_early", {7'd0, link.sync_err}, 8'd1);
    for (int k = 1; k < 8; k++) cycle(1'b1, 1'b0, 1'((8'h5A >> k) & 1), "realigned");
    check("y_5a", link.y, 8'h5A);

    // Async reset mid-frame with gapped strobes.
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, k == 0, 1'b1, "gapped");
      idle(3, "gapped_idle");
    end
    @(negedge clk);
    link.en = 1'b1; link.sync = 1'b0; link.din = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    link.en = 1'b0;
    send_frame(8'hC3, 1'b1, 3, "post_reset");
    check("y_c3", link.y, 8'hC3);

    // Randomized traffic: mostly well-formed frames with occasional faults.
    for (int f = 0; f < 150; f++) begin
      bit [7:0] data = 8'($urandom);
      for (int k = 0; k < 8; k++) begin
        bit s = (k == 0) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 39) == 0);
        cycle(1'b1, s, data[k], "random");
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), "random_idle");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_tdm_demux8
